vend_txn_ctrl: RTL
==================

# vend_txn_ctrl

Transaction sequencer for the vending-machine datapath. It takes the price selection from the slide switches and single-cycle coin pulses from the debounced btnL/btnR/btnD, then accumulates credit and decides when to dispense, return change or refund. Its credit, price and return-amount outputs feed the 7-segment display mux, and its status flags drive the LEDs.

## Interface
Parameters:
- DISP_CYCLES, 100, cycles the dispense output is held high
- RET_CYCLES, 100, cycles a nonzero return amount is presented
- TIMEOUT_CYCLES, 10000, idle cycles in COLLECT before an automatic refund

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- price_sw  in  4  price-select switches (sw[3:0])
- coin  in  3  single-cycle coin pulses: [0]=$2 (btnL), [1]=$5 (btnR), [2]=$10 (btnD)
- cancel  in  1  single-cycle cancel pulse (btnC)
- price  out  8  latched price in dollars
- credit  out  8  accumulated credit in dollars
- ret_amt  out  8  change or refund amount; valid while ret_valid=1
- ret_valid  out  1  return amount being presented
- dispense  out  1  item-release strobe, held DISP_CYCLES cycles
- coin_rej  out  1  one-cycle pulse when an inserted coin is not accepted
- state  out  3  current FSM state encoding, for LEDs and debug

## Operation
- Price decode uses priority, highest index wins: sw[3]=$15, sw[2]=$12, sw[1]=$10, sw[0]=$8. No bit set means price 0, which means "no selection".
- States:
  - IDLE: price 0. A nonzero selection moves to ARMED.
  - ARMED: price tracks price_sw live. Selection returning to 0 goes to IDLE. Cancel goes to IDLE. Any coin latches the price, adds the coin values and goes to COLLECT.
  - COLLECT: price is frozen and switch changes are ignored.
    - On coin, credit += the sum of all asserted coin bits; simultaneous bits are all counted.
    - When the new credit is ≥ price, go to DISPENSE.
    - On cancel, go to RETURN with ret_amt = credit plus any coin in the same cycle. Cancel wins over reaching the price.
    - After TIMEOUT_CYCLES with no coin, go to RETURN with ret_amt = credit. Each coin reloads the timer.
  - DISPENSE: dispense=1 for DISP_CYCLES. Then go to RETURN if change = credit − price is greater than 0, else to IDLE.
  - RETURN: ret_valid=1 and ret_amt is stable for RET_CYCLES. Then credit is cleared, and the FSM goes to ARMED if price_sw is nonzero, else to IDLE.
- Coins arriving in DISPENSE or RETURN are not counted; coin_rej pulses for one cycle. Cancel in those states is ignored.
- Arithmetic: 8-bit unsigned. Maximum credit is 14+17=31, so no overflow is possible. Change is computed once, on entry to DISPENSE.

## Timing
- Reset values: state=IDLE, price=0, credit=0, ret_amt=0, ret_valid=0, dispense=0, coin_rej=0. Reset can occur in any state and takes effect immediately, aborting the transaction; no refund is issued.
- Coin pulse at edge t: credit is updated and visible after edge t+1, and the state change to COLLECT or DISPENSE happens at the same edge.
- dispense rises 1 cycle after the qualifying coin and stays high for exactly DISP_CYCLES cycles.
- ret_valid rises the cycle after dispense falls, or 1 cycle after cancel/timeout, and stays high for exactly RET_CYCLES cycles. ret_amt returns to 0 when ret_valid falls.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- VEND_CHANGE_EN defined: behaviour is as described above.
- VEND_CHANGE_EN undefined:
  - Overpayment is kept by the machine and DISPENSE always exits to IDLE/ARMED.
  - RETURN is entered only from cancel or timeout.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE, ARMED, COLLECT, DISPENSE, RETURN)
  - price constants (8, 10, 12, 15)
  - coin values (2, 5, 10)
  - the 8-bit money width
- Sub-module vend_timer: a loadable down-counter with load, count-enable and done outputs. One instance is shared across the DISPENSE, RETURN and timeout intervals because they never overlap.

## Test plan
- Price $12 (sw[2]) with coins $2, $5, $10 on separate cycles:
  - credit goes 2, 7, 17, then DISPENSE.
  - With VEND_CHANGE_EN, RETURN follows with ret_amt=5.
  - Without it, the FSM returns to ARMED with no RETURN.
- Price $8 (sw[0]) with a single $10: dispense for DISP_CYCLES, then ret_amt=2.
- Price $15 with $5, then cancel: RETURN with ret_amt=5, no dispense, credit cleared afterwards.
- Price $10 with $2 and $5 asserted in the same cycle: credit=7 and state stays COLLECT. Then $5 gives credit=12, DISPENSE, and change 2.
- Price $12 with $2 and no further coins for TIMEOUT_CYCLES: automatic RETURN with ret_amt=2. Also cover a coin during DISPENSE: coin_rej pulses and credit is unchanged.
- Reset asserted mid-DISPENSE: all outputs go to their reset values immediately. After release with sw[2]=1, the FSM is in ARMED with credit 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
package vend_pkg;

  localparam int MONEY_W = 8;
  localparam int TIMER_W = 16;

  typedef logic [MONEY_W-1:0] money_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    COLLECT  = 3'd2,
    DISPENSE = 3'd3,
    RETURN   = 3'd4
  } state_e;

  localparam money_t PRICE_SW0 = 8'd8;
  localparam money_t PRICE_SW1 = 8'd10;
  localparam money_t PRICE_SW2 = 8'd12;
  localparam money_t PRICE_SW3 = 8'd15;

  localparam money_t COIN_L = 8'd2;
  localparam money_t COIN_R = 8'd5;
  localparam money_t COIN_D = 8'd10;

  // Highest switch index wins; no switch set means "no selection".
  function automatic money_t decode_price(input logic [3:0] sw);
    money_t p;
    if (sw[3])      p = PRICE_SW3;
    else if (sw[2]) p = PRICE_SW2;
    else if (sw[1]) p = PRICE_SW1;
    else if (sw[0]) p = PRICE_SW0;
    else            p = '0;
    return p;
  endfunction

  function automatic money_t coin_value(input logic [2:0] c);
    money_t v;
    v = (c[0] ? COIN_L : '0) + (c[1] ? COIN_R : '0) + (c[2] ? COIN_D : '0);
    return v;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the dispense, return and timeout intervals.
module vend_timer
  import vend_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit accumulation, dispense, change and refund.
// Define VEND_CHANGE_EN to return overpayment as change after dispensing.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int DISP_CYCLES    = 100,
  parameter int RET_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] price_sw,
  input  logic [2:0] coin,
  input  logic       cancel,
  output logic [7:0] price,
  output logic [7:0] credit,
  output logic [7:0] ret_amt,
  output logic       ret_valid,
  output logic       dispense,
  output logic       coin_rej,
  output logic [2:0] state
);

  // Timer loads are one less than the interval: the exit edge happens at count zero.
  localparam logic [TIMER_W-1:0] DISP_LOAD = TIMER_W'(DISP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RET_LOAD  = TIMER_W'(RET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD   = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  money_t price_q, price_d;
  money_t credit_q, credit_d;
  money_t ret_amt_q, ret_amt_d;
  logic   ret_valid_q, ret_valid_d;
  logic   dispense_q, dispense_d;
  logic   coin_rej_q, coin_rej_d;
`ifdef VEND_CHANGE_EN
  money_t change_q, change_d;
`endif

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_en;
  logic               timer_done;

  money_t sw_price;
  money_t coin_val;
  money_t new_credit;
  money_t eff_price;
  logic   any_coin;

  assign sw_price   = decode_price(price_sw);
  assign coin_val   = coin_value(coin);
  assign any_coin   = |coin;
  assign new_credit = credit_q + coin_val;
  assign eff_price  = (state_q == ARMED) ? sw_price : price_q;

  vend_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    price_d     = price_q;
    credit_d    = credit_q;
    ret_amt_d   = ret_amt_q;
    ret_valid_d = ret_valid_q;
    dispense_d  = dispense_q;
    coin_rej_d  = 1'b0;
`ifdef VEND_CHANGE_EN
    change_d    = change_q;
`endif
    timer_load  = 1'b0;
    timer_val   = '0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        price_d    = sw_price;
        coin_rej_d = any_coin;
        if (sw_price != '0) state_d = ARMED;
      end

      ARMED: begin
        price_d = sw_price;
        if ((sw_price == '0) || cancel) begin
          state_d    = IDLE;
          price_d    = '0;
          coin_rej_d = any_coin;
        end else if (any_coin) begin
          credit_d = new_credit;
          if (new_credit >= eff_price) begin
            state_d    = DISPENSE;
            dispense_d = 1'b1;
            timer_load = 1'b1;
            timer_val  = DISP_LOAD;
`ifdef VEND_CHANGE_EN
            change_d   = new_credit - eff_price;
`endif
          end else begin
            state_d    = COLLECT;
            timer_load = 1'b1;
            timer_val  = TO_LOAD;
          end
        end
      end

      // Cancel is checked first so it beats a coin that would reach the price.
      COLLECT: begin
        if (cancel) begin
          state_d     = RETURN;
          credit_d    = new_credit;
          ret_amt_d   = new_credit;
          ret_valid_d = 1'b1;
          timer_load  = 1'b1;
          timer_val   = RET_LOAD;
        end else if (any_coin) begin
          credit_d   = new_credit;
          timer_load = 1'b1;
          if (new_credit >= eff_price) begin
            state_d    = DISPENSE;
            dispense_d = 1'b1;
            timer_val  = DISP_LOAD;
`ifdef VEND_CHANGE_EN
            change_d   = new_credit - eff_price;
`endif
          end else begin
            timer_val = TO_LOAD;
          end
        end else if (timer_done) begin
          state_d     = RETURN;
          ret_amt_d   = credit_q;
          ret_valid_d = 1'b1;
          timer_load  = 1'b1;
          timer_val   = RET_LOAD;
        end else begin
          timer_en = 1'b1;
        end
      end

      DISPENSE: begin
        coin_rej_d = any_coin;
        if (timer_done) begin
          dispense_d = 1'b0;
`ifdef VEND_CHANGE_EN
          if (change_q != '0) begin
            state_d     = RETURN;
            ret_amt_d   = change_q;
            ret_valid_d = 1'b1;
            timer_load  = 1'b1;
            timer_val   = RET_LOAD;
          end else begin
            state_d  = (sw_price != '0) ? ARMED : IDLE;
            price_d  = sw_price;
            credit_d = '0;
          end
`else
          state_d  = (sw_price != '0) ? ARMED : IDLE;
          price_d  = sw_price;
          credit_d = '0;
`endif
        end else begin
          timer_en = 1'b1;
        end
      end

      RETURN: begin
        coin_rej_d = any_coin;
        if (timer_done) begin
          state_d     = (sw_price != '0) ? ARMED : IDLE;
          price_d     = sw_price;
          credit_d    = '0;
          ret_amt_d   = '0;
          ret_valid_d = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        price_d     = '0;
        credit_d    = '0;
        ret_amt_d   = '0;
        ret_valid_d = 1'b0;
        dispense_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      price_q     <= '0;
      credit_q    <= '0;
      ret_amt_q   <= '0;
      ret_valid_q <= 1'b0;
      dispense_q  <= 1'b0;
      coin_rej_q  <= 1'b0;
`ifdef VEND_CHANGE_EN
      change_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      price_q     <= price_d;
      credit_q    <= credit_d;
      ret_amt_q   <= ret_amt_d;
      ret_valid_q <= ret_valid_d;
      dispense_q  <= dispense_d;
      coin_rej_q  <= coin_rej_d;
`ifdef VEND_CHANGE_EN
      change_q    <= change_d;
`endif
    end
  end

  assign state     = state_q;
  assign price     = price_q;
  assign credit    = credit_q;
  assign ret_amt   = ret_amt_q;
  assign ret_valid = ret_valid_q;
  assign dispense  = dispense_q;
  assign coin_rej  = coin_rej_q;

endmodule
